// File: rtl/signal_1_hz_monitor.sv
// Receive-side checker for the 1 Hz timing marker: synchronises the pulse, measures
// period and high-time, qualifies lock and reports period/width/missing-pulse errors.
module signal_1_hz_monitor #(
   parameter int CLK_HZ    = 5_000_000,
   parameter int TOL       = 50,
   parameter int WIDTH_MIN = 3,
   parameter int WIDTH_MAX = 10,
   parameter int LOCK_CNT  = 3,
   parameter int CNT_W     = 23
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   output logic             locked,
   output logic             pulse_ok,
   output logic             err_period,
   output logic             err_width,
   output logic             err_missing,
   output logic [CNT_W-1:0] period_meas,
   output logic [7:0]       width_meas,
   output logic [15:0]      err_cnt
);

   localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0]  P_MIN     = CNT_W'(CLK_HZ - TOL);
   localparam logic [CNT_W-1:0]  P_MAX     = CNT_W'(CLK_HZ + TOL);
   localparam logic [7:0]        W_MIN     = 8'(WIDTH_MIN);
   localparam logic [7:0]        W_MAX     = 8'(WIDTH_MAX);
   localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_CNT);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {
      SEARCH,
      LOCKING,
      LOCKED
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_next;
   logic              wbad;
   logic              wbad_next;

   logic              sync1;
   logic              sync2;
   logic              sync3;
   logic              armed;
   logic              rise;
   logic              fall;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  period;
   logic [7:0]        width;

   logic              width_short;
   logic              width_long;
   logic              width_err;
   logic              ok_strobe;
   logic              period_strobe;
   logic              missing_strobe;
   logic              any_err;

   // Chain resets high and edges stay masked until a low level is seen, so a pulse
   // already high when reset lifts must go low and high again to count as a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
         armed <= 1'b0;
      end else begin
         sync1 <= pulse_in;
         sync2 <= sync1;
         sync3 <= sync2;
         if (!sync2) begin
            armed <= 1'b1;
         end
      end
   end

   assign rise   = armed & sync2 & ~sync3;
   assign fall   = armed & ~sync2 & sync3;
   assign period = cnt + 1'b1;

   // The stuck-high strobe fires on the cycle width steps from WIDTH_MAX to WIDTH_MAX+1;
   // a long pulse has already been flagged by then, so the fall only judges short ones.
   assign width_short = fall && (width < W_MIN);
   assign width_long  = armed && sync2 && !rise && (width == W_MAX);
   assign width_err   = width_short | width_long;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SEARCH;
         good_cnt <= '0;
         wbad     <= 1'b0;
      end else begin
         state    <= state_next;
         good_cnt <= good_next;
         wbad     <= wbad_next;
      end
   end

   always_comb begin
      state_next     = state;
      good_next      = good_cnt;
      wbad_next      = wbad;
      ok_strobe      = 1'b0;
      period_strobe  = 1'b0;
      missing_strobe = 1'b0;

      if (width_err) begin
         wbad_next = 1'b1;
         if (state == LOCKED) begin
            state_next = LOCKING;
            good_next  = '0;
         end
      end

      case (state)
         SEARCH: begin
            if (rise) begin
               state_next = LOCKING;
               good_next  = '0;
               wbad_next  = 1'b0;
            end
         end
         LOCKING, LOCKED: begin
            if (rise) begin
               wbad_next = 1'b0;
               if ((period < P_MIN) || (period > P_MAX)) begin
                  period_strobe = 1'b1;
                  good_next     = '0;
                  state_next    = LOCKING;
               end else if (wbad) begin
                  good_next  = '0;
                  state_next = LOCKING;
               end else begin
                  ok_strobe = 1'b1;
                  if (good_cnt >= GOOD_LAST) begin
                     good_next  = GOOD_FULL;
                     state_next = LOCKED;
                  end else begin
                     good_next = good_cnt + 1'b1;
                  end
               end
            end else if (cnt == P_MAX) begin
               missing_strobe = 1'b1;
               good_next      = '0;
               state_next     = SEARCH;
            end
         end
         default: begin
            state_next = SEARCH;
            good_next  = '0;
            wbad_next  = 1'b0;
         end
      endcase
   end

   always_comb begin
      locked = (state == LOCKED);
   end

   assign any_err = period_strobe | width_err | missing_strobe;

   // Measurement counters and registered strobes; the period counter idles at zero
   // while searching and restarts on every accepted rise or missing-pulse timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         period_meas <= '0;
         width       <= '0;
         width_meas  <= '0;
         pulse_ok    <= 1'b0;
         err_period  <= 1'b0;
         err_width   <= 1'b0;
         err_missing <= 1'b0;
         err_cnt     <= '0;
      end else begin
         pulse_ok    <= ok_strobe;
         err_period  <= period_strobe;
         err_width   <= width_err;
         err_missing <= missing_strobe;

         if (rise) begin
            period_meas <= period;
            cnt         <= '0;
         end else if (missing_strobe || (state == SEARCH)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // The rise cycle itself is the first high cycle of the pulse.
         if (rise) begin
            width <= 8'd1;
         end else if (armed && sync2 && (width != 8'hFF)) begin
            width <= width + 1'b1;
         end

         if (fall) begin
            width_meas <= width;
         end

         if (any_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_signal_1_hz_monitor.sv
// Directed bench for signal_1_hz_monitor with a 100-cycle nominal period; each pulse
// window tallies the strobes it produces and the cycle offsets at which they appear.
module tb_signal_1_hz_monitor;

   logic        clk;
   logic        rst_n;
   logic        pulse_in;
   logic        locked;
   logic        pulse_ok;
   logic        err_period;
   logic        err_width;
   logic        err_missing;
   logic [22:0] period_meas;
   logic [7:0]  width_meas;
   logic [15:0] err_cnt;

   int checks;
   int errors;
   int win_cyc;
   int n_ok;
   int n_perr;
   int n_wid;
   int n_miss;
   int wid_at;
   int miss_at;
   int lock_hi_at;
   int lock_lo_at;

   signal_1_hz_monitor #(
      .CLK_HZ   (100),
      .TOL      (2),
      .WIDTH_MIN(3),
      .WIDTH_MAX(10),
      .LOCK_CNT (3),
      .CNT_W    (23)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pulse_in   (pulse_in),
      .locked     (locked),
      .pulse_ok   (pulse_ok),
      .err_period (err_period),
      .err_width  (err_width),
      .err_missing(err_missing),
      .period_meas(period_meas),
      .width_meas (width_meas),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic clear_window();
      win_cyc    = 0;
      n_ok       = 0;
      n_perr     = 0;
      n_wid      = 0;
      n_miss     = 0;
      wid_at     = -1;
      miss_at    = -1;
      lock_hi_at = -1;
      lock_lo_at = -1;
   endtask

   // Outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (pulse_ok) n_ok++;
      if (err_period) n_perr++;
      if (err_width) begin
         n_wid++;
         if (wid_at < 0) wid_at = win_cyc;
      end
      if (err_missing) begin
         n_miss++;
         if (miss_at < 0) miss_at = win_cyc;
      end
      if (locked && (lock_hi_at < 0)) lock_hi_at = win_cyc;
      if (!locked && (lock_lo_at < 0)) lock_lo_at = win_cyc;
      win_cyc++;
   endtask

   task automatic hold(input logic level, input int n);
      pulse_in = level;
      for (int i = 0; i < n; i++) tick();
   endtask

   // One pulse of the given high-time, followed by low until the next pulse is due.
   task automatic apply_stimulus(input int width, input int period);
      clear_window();
      hold(1'b1, width);
      hold(1'b0, period - width);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      pulse_in = 1'b0;
      clear_window();

      repeat (3) @(posedge clk);
      #1;
      check_output("reset_locked",      32'(locked),      32'd0);
      check_output("reset_pulse_ok",    32'(pulse_ok),    32'd0);
      check_output("reset_err_period",  32'(err_period),  32'd0);
      check_output("reset_err_width",   32'(err_width),   32'd0);
      check_output("reset_err_missing", 32'(err_missing), 32'd0);
      check_output("reset_period_meas", 32'(period_meas), 32'd0);
      check_output("reset_width_meas",  32'(width_meas),  32'd0);
      check_output("reset_err_cnt",     32'(err_cnt),     32'd0);
      rst_n = 1'b1;
      hold(1'b0, 5);

      $display("[TB] lock acquisition with nominal pulses");
      apply_stimulus(5, 100);
      check_output("t1_first_rise_ok",   n_ok,          0);
      check_output("t1_first_rise_perr", n_perr,        0);
      check_output("t1_first_locked",    32'(locked),   32'd0);
      apply_stimulus(5, 100);
      check_output("t1_rise2_ok",        n_ok,          1);
      apply_stimulus(5, 100);
      check_output("t1_rise3_ok",        n_ok,          1);
      check_output("t1_rise3_locked",    32'(locked),   32'd0);
      apply_stimulus(5, 100);
      check_output("t1_rise4_ok",        n_ok,          1);
      check_output("t1_lock_offset",     lock_hi_at,    2);
      check_output("t1_period_meas",     32'(period_meas), 32'd100);
      check_output("t1_width_meas",      32'(width_meas),  32'd5);
      check_output("t1_err_cnt",         32'(err_cnt),     32'd0);

      $display("[TB] short period while locked");
      apply_stimulus(5, 97);
      check_output("t2_pre_ok",          n_ok,          1);
      apply_stimulus(5, 100);
      check_output("t2_perr",            n_perr,        1);
      check_output("t2_no_ok",           n_ok,          0);
      check_output("t2_unlock_offset",   lock_lo_at,    2);
      check_output("t2_period_meas",     32'(period_meas), 32'd97);
      apply_stimulus(5, 100);
      check_output("t2_relock1_ok",      n_ok,          1);
      check_output("t2_relock1_locked",  32'(locked),   32'd0);
      apply_stimulus(5, 100);
      check_output("t2_relock2_ok",      n_ok,          1);
      check_output("t2_relock2_locked",  32'(locked),   32'd0);
      apply_stimulus(5, 100);
      check_output("t2_relock3_ok",      n_ok,          1);
      check_output("t2_relock_offset",   lock_hi_at,    2);
      check_output("t2_err_cnt",         32'(err_cnt),  32'd1);

      $display("[TB] tolerance edges");
      apply_stimulus(5, 98);
      check_output("t3_a_ok",            n_ok,          1);
      apply_stimulus(5, 102);
      check_output("t3_p98_ok",          n_ok,          1);
      check_output("t3_p98_stay_locked", lock_lo_at,    -1);
      check_output("t3_p98_meas",        32'(period_meas), 32'd98);
      apply_stimulus(5, 100);
      check_output("t3_p102_ok",         n_ok,          1);
      check_output("t3_p102_perr",       n_perr,        0);
      check_output("t3_p102_stay_locked", lock_lo_at,   -1);
      check_output("t3_p102_meas",       32'(period_meas), 32'd102);

      // Counter clears as the rise strobe registers (offset 2) and reaches 102 at offset 104,
      // so the missing strobe registers at offset 105.
      $display("[TB] missing pulse");
      apply_stimulus(5, 120);
      check_output("t4_last_ok",         n_ok,          1);
      check_output("t4_miss_count",      n_miss,        1);
      check_output("t4_miss_offset",     miss_at,       105);
      check_output("t4_unlock_offset",   lock_lo_at,    105);
      check_output("t4_err_cnt",         32'(err_cnt),  32'd2);
      apply_stimulus(5, 100);
      check_output("t4_search_ok",       n_ok,          0);
      check_output("t4_search_perr",     n_perr,        0);
      check_output("t4_search_miss",     n_miss,        0);
      check_output("t4_search_locked",   32'(locked),   32'd0);

      $display("[TB] width errors");
      repeat (3) apply_stimulus(5, 100);
      check_output("t5_locked_a",        32'(locked),   32'd1);
      apply_stimulus(2, 100);
      check_output("t5_short_rise_ok",   n_ok,          1);
      check_output("t5_short_wid",       n_wid,         1);
      check_output("t5_short_offset",    wid_at,        4);
      check_output("t5_short_unlock",    lock_lo_at,    4);
      check_output("t5_short_meas",      32'(width_meas), 32'd2);
      check_output("t5_short_err_cnt",   32'(err_cnt),  32'd3);
      apply_stimulus(5, 100);
      check_output("t5_wbad_ok",         n_ok,          0);
      check_output("t5_wbad_perr",       n_perr,        0);
      repeat (3) apply_stimulus(5, 100);
      check_output("t5_locked_b",        32'(locked),   32'd1);
      apply_stimulus(40, 100);
      check_output("t5_stuck_rise_ok",   n_ok,          1);
      check_output("t5_stuck_wid",       n_wid,         1);
      check_output("t5_stuck_offset",    wid_at,        12);
      check_output("t5_stuck_unlock",    lock_lo_at,    12);
      check_output("t5_stuck_meas",      32'(width_meas), 32'd40);
      check_output("t5_stuck_err_cnt",   32'(err_cnt),  32'd4);
      apply_stimulus(5, 100);
      check_output("t5_wbad2_ok",        n_ok,          0);

      $display("[TB] reset mid-pulse");
      repeat (3) apply_stimulus(5, 100);
      check_output("t6_locked",          32'(locked),   32'd1);
      clear_window();
      hold(1'b1, 3);
      check_output("t6_pre_reset_ok",    n_ok,          1);
      rst_n = 1'b0;
      #1;
      check_output("t6_async_locked",    32'(locked),      32'd0);
      check_output("t6_async_period",    32'(period_meas), 32'd0);
      check_output("t6_async_width",     32'(width_meas),  32'd0);
      check_output("t6_async_err_cnt",   32'(err_cnt),     32'd0);
      hold(1'b1, 2);
      rst_n = 1'b1;
      clear_window();
      hold(1'b1, 20);
      hold(1'b0, 20);
      check_output("t6_held_ok",         n_ok,          0);
      check_output("t6_held_wid",        n_wid,         0);
      check_output("t6_held_perr",       n_perr,        0);
      check_output("t6_held_miss",       n_miss,        0);
      check_output("t6_held_width_meas", 32'(width_meas), 32'd0);
      apply_stimulus(5, 100);
      check_output("t6_first_ok",        n_ok,          0);
      apply_stimulus(5, 100);
      check_output("t6_second_ok",       n_ok,          1);
      check_output("t6_second_period",   32'(period_meas), 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
